// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared load/store unit encodings
package lsu_pkg;

  localparam int EXE_INST_OP_W      = 3;
  localparam int EXE_INFO_SEL_W     = 8;
  localparam int EXE_INFO_BUS_WIDTH = EXE_INFO_SEL_W + EXE_INST_OP_W;
  localparam int MEM_BE_W           = 4;

  localparam logic [EXE_INST_OP_W-1:0] EXE_INST_OP = 3'd0;
  localparam logic [EXE_INST_OP_W-1:0] EXE_INST_L  = 3'd1;
  localparam logic [EXE_INST_OP_W-1:0] EXE_INST_S  = 3'd2;

  // One-hot access-size bits in the low byte of the info bus
  localparam int EXE_INST_L_B  = 0;
  localparam int EXE_INST_L_H  = 1;
  localparam int EXE_INST_L_W  = 2;
  localparam int EXE_INST_L_BU = 3;
  localparam int EXE_INST_L_HU = 4;
  localparam int EXE_INST_S_B  = 5;
  localparam int EXE_INST_S_H  = 6;
  localparam int EXE_INST_S_W  = 7;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, alignment check and load formatting
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]                off,
  input  logic [EXE_INFO_SEL_W-1:0] info,
  input  logic [31:0]               st_data,
  input  logic [31:0]               rdata,
  output logic [MEM_BE_W-1:0]       be,
  output logic [31:0]               wdata,
  output logic                      misalign,
  output logic [31:0]               ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    be    = 4'b1111;
    wdata = st_data;
    if (info[EXE_INST_S_B]) begin
      be    = 4'b0001 << off;
      wdata = {4{st_data[7:0]}};
    end else if (info[EXE_INST_S_H]) begin
      be    = 4'b0011 << {off[1], 1'b0};
      wdata = {2{st_data[15:0]}};
    end

    misalign = ((info[EXE_INST_L_H] | info[EXE_INST_L_HU] | info[EXE_INST_S_H]) & off[0])
             | ((info[EXE_INST_L_W] | info[EXE_INST_S_W]) & (off != 2'b00));

    ld_data = rdata;
    if (info[EXE_INST_L_B])       ld_data = {{24{byte_sel[7]}}, byte_sel};
    else if (info[EXE_INST_L_BU]) ld_data = {24'd0, byte_sel};
    else if (info[EXE_INST_L_H])  ld_data = {{16{half_sel[15]}}, half_sel};
    else if (info[EXE_INST_L_HU]) ld_data = {16'd0, half_sel};
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: data-bus handshake and registered writeback
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_ADDR_W = 32,
  parameter int DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_we_i,
  input  logic [DATA_W-1:0]             rd_mem_data_i,
  input  logic [4:0]                    rd_addr_i,
  input  logic                          csr_we_i,
  input  logic [DATA_W-1:0]             csr_wdata_i,
  input  logic [11:0]                   csr_waddr_i,
  input  logic [MEM_ADDR_W-1:0]         mem_addr_i,
  input  logic [EXE_INFO_BUS_WIDTH-1:0] exe_info_bus_i,
  output logic                          mem_req_o,
  input  logic                          mem_gnt_i,
  output logic                          mem_we_o,
  output logic [MEM_BE_W-1:0]           mem_be_o,
  output logic [MEM_ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic                          mem_rvalid_i,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  output logic                          rd_we_o,
  output logic [DATA_W-1:0]             rd_data_o,
  output logic [4:0]                    rd_addr_o,
  output logic                          csr_we_o,
  output logic [DATA_W-1:0]             csr_wdata_o,
  output logic [11:0]                   csr_waddr_o,
  output logic                          misalign_o,
  output logic                          stallreq_o
);

  lsu_state_e                 state;
  logic [DATA_W-1:0]          ld_buf;
  logic [EXE_INST_OP_W-1:0]   op;
  logic                       is_load, is_store, is_mem, issue;
  logic [MEM_BE_W-1:0]        be;
  logic [DATA_W-1:0]          wdata, ld_data;
  logic                       misalign;

  lsu_align u_align (
    .off      (mem_addr_i[1:0]),
    .info     (exe_info_bus_i[EXE_INFO_SEL_W-1:0]),
    .st_data  (rd_mem_data_i),
    .rdata    (mem_rdata_i),
    .be       (be),
    .wdata    (wdata),
    .misalign (misalign),
    .ld_data  (ld_data)
  );

  // Bus outputs are forced to zero whenever no request is on the bus, so reset clears them at once.
  always_comb begin
    op         = exe_info_bus_i[EXE_INFO_BUS_WIDTH-1 -: EXE_INST_OP_W];
    is_load    = (op == EXE_INST_L);
    is_store   = (op == EXE_INST_S);
    is_mem     = is_load | is_store;
    issue      = is_mem & ~misalign;
    mem_req_o  = rst_n & (((state == LSU_IDLE) & issue) | (state == LSU_REQ));
    stallreq_o = mem_req_o | (rst_n & (state == LSU_RESP));
    mem_we_o   = mem_req_o & is_store;
    mem_be_o   = mem_req_o ? be : '0;
    mem_addr_o = mem_req_o ? {mem_addr_i[MEM_ADDR_W-1:2], 2'b00} : '0;
    mem_wdata_o = (mem_req_o & is_store) ? wdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LSU_IDLE;
      ld_buf      <= '0;
      rd_we_o     <= 1'b0;
      rd_data_o   <= '0;
      rd_addr_o   <= '0;
      csr_we_o    <= 1'b0;
      csr_wdata_o <= '0;
      csr_waddr_o <= '0;
      misalign_o  <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: if (issue) state <= mem_gnt_i ? (is_store ? LSU_DONE : LSU_RESP) : LSU_REQ;
        LSU_REQ:  if (mem_gnt_i) state <= is_store ? LSU_DONE : LSU_RESP;
        LSU_RESP: if (mem_rvalid_i) begin
          ld_buf <= ld_data;
          state  <= LSU_DONE;
        end
        default:  state <= LSU_IDLE;
      endcase

      if (stallreq_o) begin
        rd_we_o     <= 1'b0;
        rd_data_o   <= '0;
        rd_addr_o   <= '0;
        csr_we_o    <= 1'b0;
        csr_wdata_o <= '0;
        csr_waddr_o <= '0;
        misalign_o  <= 1'b0;
      end else begin
        rd_we_o     <= rd_we_i;
        rd_data_o   <= rd_mem_data_i;
        rd_addr_o   <= rd_addr_i;
        csr_we_o    <= csr_we_i;
        csr_wdata_o <= csr_wdata_i;
        csr_waddr_o <= csr_waddr_i;
        misalign_o  <= 1'b0;
        // DONE retires the access still sitting on the inputs without re-issuing it
        if (state == LSU_DONE) begin
          if (is_load) rd_data_o <= ld_buf;
          else         rd_we_o   <= 1'b0;
        end else if (is_mem & misalign) begin
          misalign_o <= 1'b1;
          rd_we_o    <= 1'b0;
          csr_we_o   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized self-checking bench for lsu
module tb_lsu;
  import lsu_pkg::*;

  localparam int K_ALU = 0, K_LB = 1, K_LH = 2, K_LW = 3, K_LBU = 4, K_LHU = 5;
  localparam int K_SB = 6, K_SH = 7, K_SW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_we_i = 1'b0;
  logic [31:0] rd_mem_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        csr_we_i = 1'b0;
  logic [31:0] csr_wdata_i = '0;
  logic [11:0] csr_waddr_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [EXE_INFO_BUS_WIDTH-1:0] exe_info_bus_i = '0;
  logic        mem_req_o, mem_we_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        rd_we_o, csr_we_o, misalign_o, stallreq_o;
  logic [31:0] rd_data_o, csr_wdata_o;
  logic [4:0]  rd_addr_o;
  logic [11:0] csr_waddr_o;

  lsu dut (
    .clk(clk), .rst_n(rst_n), .rd_we_i(rd_we_i), .rd_mem_data_i(rd_mem_data_i),
    .rd_addr_i(rd_addr_i), .csr_we_i(csr_we_i), .csr_wdata_i(csr_wdata_i),
    .csr_waddr_i(csr_waddr_i), .mem_addr_i(mem_addr_i), .exe_info_bus_i(exe_info_bus_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .rd_we_o(rd_we_o), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
    .csr_we_o(csr_we_o), .csr_wdata_o(csr_wdata_o), .csr_waddr_o(csr_waddr_o),
    .misalign_o(misalign_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic        rd_we;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [11:0] csr_waddr;
    logic [31:0] addr;
  } instr_t;

  typedef struct {
    logic        g;
    logic        v;
    logic [31:0] d;
  } beat_t;

  instr_t cur;
  beat_t  script[$];
  bit     rand_mode = 1'b0;
  int     total = 0, bad = 0, grant_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EXE_INFO_BUS_WIDTH-1:0] info_of(input int kind);
    logic [7:0] oh;
    oh = '0;
    if (kind == K_ALU) return {EXE_INST_OP, 8'd0};
    oh[kind-1] = 1'b1;
    return (kind <= K_LHU) ? {EXE_INST_L, oh} : {EXE_INST_S, oh};
  endfunction

  function automatic bit m_store(input int k); return k >= K_SB; endfunction
  function automatic bit m_load(input int k); return k >= K_LB && k <= K_LHU; endfunction

  function automatic bit m_misal(input int k, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if ((k == K_LH || k == K_LHU || k == K_SH) && (off % 2 == 1)) return 1'b1;
    if ((k == K_LW || k == K_SW) && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_be(input int k, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (k == K_SB) return 32'(1 << off);
    if (k == K_SH) return 32'(3 << (off / 2 * 2));
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input int k, input logic [31:0] d);
    if (k == K_SB) return (d % 256) * 32'h01010101;
    if (k == K_SH) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_fmt(input int k, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] b, h;
    int off;
    off = int'(a % 4);
    b = (r >> (8 * off)) % 256;
    h = (r >> (16 * (off / 2))) % 65536;
    case (k)
      K_LB:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      K_LBU:   return b;
      K_LH:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      K_LHU:   return h;
      default: return r;
    endcase
  endfunction

  // Behavioural model: an access is outstanding until granted (and, for loads, answered).
  bit          granted = 0, responded = 0;
  logic [31:0] buf_data = '0;
  logic        e_we = 0, e_cwe = 0, e_mis = 0;
  logic [31:0] e_data = '0, e_cdata = '0;
  logic [4:0]  e_addr = '0;
  logic [11:0] e_caddr = '0;
  bit          st, rq;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_stall", stallreq_o, 0);
      check("reset_req", mem_req_o, 0);
      check("reset_rd_we", rd_we_o, 0);
      granted = 0; responded = 0;
      e_we = 0; e_cwe = 0; e_mis = 0;
    end else begin
      check("wb_rd_we", rd_we_o, e_we);
      check("wb_csr_we", csr_we_o, e_cwe);
      check("wb_misalign", misalign_o, e_mis);
      if (e_we) begin
        check("wb_rd_data", rd_data_o, e_data);
        check("wb_rd_addr", rd_addr_o, e_addr);
      end
      if (e_cwe) begin
        check("wb_csr_wdata", csr_wdata_o, e_cdata);
        check("wb_csr_waddr", csr_waddr_o, e_caddr);
      end
      st = cur.kind != K_ALU && !m_misal(cur.kind, cur.addr)
           && !(granted && (m_store(cur.kind) || responded));
      rq = st && !granted;
      check("stallreq", stallreq_o, st);
      check("mem_req", mem_req_o, rq);
      if (rq) begin
        check("mem_addr", mem_addr_o, cur.addr - (cur.addr % 4));
        check("mem_be", mem_be_o, m_be(cur.kind, cur.addr));
        check("mem_we", mem_we_o, m_store(cur.kind));
        if (m_store(cur.kind)) check("mem_wdata", mem_wdata_o, m_wdata(cur.kind, cur.data));
      end
      e_we = 0; e_cwe = 0; e_mis = 0;
      if (!st) begin
        e_addr = cur.rd; e_cdata = cur.csr_wdata; e_caddr = cur.csr_waddr;
        if (cur.kind == K_ALU) begin
          e_we = cur.rd_we; e_data = cur.data; e_cwe = cur.csr_we;
        end else if (m_misal(cur.kind, cur.addr)) begin
          e_mis = 1;
        end else if (m_load(cur.kind)) begin
          e_we = cur.rd_we; e_data = buf_data;
        end
      end
      if (rq && mem_gnt_i) begin
        granted = 1; grant_cnt++;
      end else if (granted && m_load(cur.kind) && !responded && mem_rvalid_i) begin
        responded = 1; buf_data = m_fmt(cur.kind, cur.addr, mem_rdata_i);
      end
      if (!st) begin granted = 0; responded = 0; end
    end
  end

  always @(posedge clk) begin
    beat_t s;
    #1;
    if (script.size() > 0) begin
      s = script.pop_front();
      mem_gnt_i = s.g; mem_rvalid_i = s.v; mem_rdata_i = s.d;
    end else if (rand_mode) begin
      mem_gnt_i    = ($urandom_range(0, 1) == 1);
      mem_rvalid_i = !mem_gnt_i && ($urandom_range(0, 1) == 1);
      mem_rdata_i  = $urandom;
    end else begin
      mem_gnt_i = 0; mem_rvalid_i = 0;
    end
  end

  task automatic apply(input instr_t i);
    cur = i;
    rd_we_i = i.rd_we; rd_mem_data_i = i.data; rd_addr_i = i.rd;
    csr_we_i = i.csr_we; csr_wdata_i = i.csr_wdata; csr_waddr_i = i.csr_waddr;
    mem_addr_i = i.addr; exe_info_bus_i = info_of(i.kind);
  endtask

  function automatic instr_t mk(input int k, input logic [31:0] a, input logic [31:0] d,
                                input logic [4:0] rd, input logic we);
    instr_t i;
    i.kind = k; i.addr = a; i.data = d; i.rd = rd; i.rd_we = we;
    i.csr_we = 0; i.csr_wdata = '0; i.csr_waddr = '0;
    return i;
  endfunction

  int          n_stall;
  logic        f_req;
  logic [31:0] f_addr, f_be, f_wdata;

  task automatic run(input instr_t i, input bit tail);
    @(posedge clk); #1;
    apply(i);
    n_stall = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 0) begin
        f_req = mem_req_o; f_addr = mem_addr_o; f_be = {28'd0, mem_be_o}; f_wdata = mem_wdata_o;
      end
      if (!stallreq_o) break;
      n_stall++;
      if (c == 59) begin
        bad++; total++;
        $display("FAIL stall_timeout act=%0d exp=<60", n_stall);
      end
    end
    if (tail) begin
      @(posedge clk); #1;
      apply(mk(K_ALU, 0, 0, 0, 0));
    end
  endtask

  instr_t ri;
  int     g0;

  initial begin
    apply(mk(K_ALU, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check("post_reset_rd_data", rd_data_o, 0);
    check("post_reset_be", {28'd0, mem_be_o}, 0);

    run(mk(K_ALU, 32'h0, 32'h7, 5'd5, 1), 1);
    check("add_stalls", n_stall, 0);
    @(negedge clk);
    check("add_rd_we", rd_we_o, 1);
    check("add_rd_addr", rd_addr_o, 5);
    check("add_rd_data", rd_data_o, 32'h7);

    script.push_back('{1'b1, 1'b0, 32'h0});
    script.push_back('{1'b0, 1'b1, 32'h80AA5511});
    run(mk(K_LB, 32'h1003, 32'h0, 5'd9, 1), 1);
    check("lb_addr", f_addr, 32'h1000);
    check("lb_stalls", n_stall, 2);
    @(negedge clk);
    check("lb_rd_data", rd_data_o, 32'hFFFFFF80);

    repeat (3) script.push_back('{1'b0, 1'b0, 32'h0});
    script.push_back('{1'b1, 1'b0, 32'h0});
    run(mk(K_SH, 32'h2002, 32'h0000BEEF, 5'd3, 1), 1);
    check("sh_be", f_be, 32'hC);
    check("sh_wdata", f_wdata, 32'hBEEFBEEF);
    check("sh_stalls", n_stall, 4);
    @(negedge clk);
    check("sh_rd_we", rd_we_o, 0);

    run(mk(K_LW, 32'h3001, 32'h0, 5'd4, 1), 1);
    check("lw_mis_req", f_req, 0);
    check("lw_mis_stalls", n_stall, 0);
    @(negedge clk);
    check("lw_mis_flag", misalign_o, 1);
    check("lw_mis_rd_we", rd_we_o, 0);
    @(negedge clk);
    check("lw_mis_flag_drop", misalign_o, 0);

    script.push_back('{1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    apply(mk(K_LHU, 32'h4000, 32'h0, 5'd6, 1));
    @(negedge clk);
    @(negedge clk);
    check("lhu_resp_stall", stallreq_o, 1);
    #2 rst_n = 0;
    apply(mk(K_ALU, 0, 0, 0, 0));
    #1;
    check("rst_req", mem_req_o, 0);
    check("rst_stall", stallreq_o, 0);
    check("rst_rd_we", rd_we_o, 0);
    check("rst_rd_data", rd_data_o, 0);
    script.push_back('{1'b0, 1'b0, 32'h0});
    script.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
    @(posedge clk); #2 rst_n = 1;
    @(negedge clk);
    @(negedge clk);
    check("stray_rvalid_stall", stallreq_o, 0);
    @(negedge clk);
    check("stray_rvalid_rd_we", rd_we_o, 0);

    g0 = grant_cnt;
    script.push_back('{1'b1, 1'b0, 32'h0});
    script.push_back('{1'b0, 1'b1, 32'h12345678});
    script.push_back('{1'b1, 1'b0, 32'h0});
    script.push_back('{1'b1, 1'b0, 32'h0});
    script.push_back('{1'b1, 1'b0, 32'h0});
    run(mk(K_LW, 32'h5000, 32'h0, 5'd7, 1), 0);
    run(mk(K_SW, 32'h5004, 32'hCAFEF00D, 5'd8, 1), 1);
    check("b2b_grants", grant_cnt - g0, 2);

    rand_mode = 1;
    for (int n = 0; n < 250; n++) begin
      ri.kind = $urandom_range(0, 8);
      ri.addr = $urandom;
      ri.data = $urandom;
      ri.rd = 5'($urandom);
      ri.rd_we = 1'($urandom);
      ri.csr_we = (ri.kind == K_ALU) ? 1'($urandom) : 1'b0;
      ri.csr_wdata = $urandom;
      ri.csr_waddr = 12'($urandom);
      run(ri, 0);
    end
    rand_mode = 0;
    run(mk(K_ALU, 0, 0, 0, 0), 1);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit. Consumer end of the execute-stage result/memory interface.
- Takes writeback info, the memory address and the load/store info bus produced by execute.
- Runs data-bus transactions over a req/gnt/rvalid handshake, formats load data and performs byte-lane steering for stores.
- Drives registered writeback outputs toward the mem/wb stage and stalls the pipeline while a memory access is outstanding.

Parameters:
- MEM_ADDR_W, 32, data-bus address width
- DATA_W, 32, data-bus and register width; only 32 is supported

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rd_we_i  in  1  register write enable from execute
- rd_mem_data_i  in  32  ALU result, or store data for stores
- rd_addr_i  in  5  destination register
- csr_we_i  in  1  CSR write enable
- csr_wdata_i  in  32  CSR write data
- csr_waddr_i  in  12  CSR address
- mem_addr_i  in  32  effective byte address
- exe_info_bus_i  in  EXE_INFO_BUS_WIDTH  op field plus one-hot LB/LH/LW/LBU/LHU or SB/SH/SW bits
- mem_req_o  out  1  bus request
- mem_gnt_i  in  1  bus grant
- mem_we_o  out  1  1 = store
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word-aligned bus address
- mem_wdata_o  out  32  lane-steered store data
- mem_rvalid_i  in  1  load response valid
- mem_rdata_i  in  32  load response word
- rd_we_o  out  1  registered writeback enable
- rd_data_o  out  32  registered writeback data
- rd_addr_o  out  5  registered destination
- csr_we_o  out  1  registered CSR enable
- csr_wdata_o  out  32  registered CSR data
- csr_waddr_o  out  12  registered CSR address
- misalign_o  out  1  one-cycle misaligned-access flag, registered
- stallreq_o  out  1  stall request to ctrl, combinational

Behaviour:
- Reset value of every output is 0. FSM resets to IDLE.
- mem op = op field equals EXE_INST_L or EXE_INST_S. Execute inputs are held stable by the pipeline while stallreq_o=1.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE, non-mem op: stallreq_o=0. Inputs are flopped to the wb outputs at the clock edge (1-cycle latency).
  - IDLE, aligned mem op: mem_req_o=1 and stallreq_o=1, combinationally in the same cycle.
    - gnt=1 on a store -> DONE.
    - gnt=1 on a load -> RESP.
    - gnt=0 -> REQ.
  - IDLE, misaligned mem op: no request, stallreq_o=0. Next cycle misalign_o=1, rd_we_o=0, csr_we_o=0.
  - REQ: mem_req_o=1, stallreq_o=1. All bus outputs are held stable until gnt. gnt transitions as in IDLE.
  - RESP: mem_req_o=0, stallreq_o=1. On mem_rvalid_i, capture formatted load data into an internal buffer -> DONE. rvalid and gnt can never coincide for the same access; a response no earlier than 1 cycle after gnt is legal.
  - DONE: stallreq_o=0, no request. The same instruction is still on the inputs and must not re-issue. At the edge:
    - load: rd_data_o = buffer, rd_we_o = rd_we_i.
    - store: rd_we_o = 0.
    - then -> IDLE.
- While stallreq_o=1, the wb outputs load a bubble (all enables 0) so writeback never repeats.
- mem_rvalid_i outside RESP is ignored.
- Minimum latencies:
  - load with immediate gnt: 3 cycles (IDLE, RESP, DONE).
  - store with immediate gnt: 2 cycles.
- Alignment rules, with off = addr[1:0]:
  - LH/LHU/SH are misaligned if off[0]=1.
  - LW/SW are misaligned if off!=0.
  - mem_addr_o = {addr[31:2], 2'b00}.
- Store lane steering:
  - SB: be = 4'b0001<<off, wdata = byte replicated x4.
  - SH: be = 4'b0011<<{off[1],1'b0}, wdata = half replicated x2.
  - SW: be = 4'b1111.
  - Loads: be = 4'b1111, mem_we_o = 0.
- Load formatting:
  - LB/LBU select rdata byte[off].
  - LH/LHU select the half at off[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Async reset mid-transaction: return to IDLE and drop mem_req_o immediately. The bus side discards any pending response.

Decomposition:
- Shared defines.v holds: EXE_INST_OP/L/S codes, EXE_INST_L_*/S_* bit indices, EXE_INFO_BUS width, LSU state encodings, MEM_BE width.
- One combinational sub-module, lsu_align: computes be, wdata, misalign and formatted load data from off, info bits and rdata.

Test Plan:
- ADD result 0x00000007 to rd=5, IDLE -> next cycle rd_we_o=1, rd_addr_o=5, rd_data_o=0x7, stallreq_o never 1.
- LB at addr 0x1003, gnt same cycle, rvalid one cycle later with rdata=0x80AA5511 -> mem_addr_o=0x1000; in DONE cycle rd_data_o is loaded =0xFFFFFF80; stall high for exactly 2 cycles.
- SH at 0x2002 with data 0x0000BEEF, gnt delayed 3 cycles -> mem_be_o=4'b1100, wdata=0xBEEFBEEF; req and outputs held stable through wait; rd_we_o=0.
- LW at 0x3001 -> no mem_req_o; misalign_o=1 for exactly one cycle; rd_we_o=0; no stall.
- LHU at 0x4000 in RESP, rst_n asserted low -> mem_req_o/stallreq_o/all outputs 0 immediately; after release FSM is IDLE and a stray rvalid is ignored.
- Back-to-back LW then SW with immediate gnt -> single request per instruction; no re-issue during DONE.
